// File: rtl/imm_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder_pkg
// Description : Immediate-format codes shared by the NPC immediate decoder
//               and encoder, plus the stored entry type used by the encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_encoder_pkg;

    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_U = 3'd1;
    localparam logic [2:0] c_IMM_S = 3'd2;
    localparam logic [2:0] c_IMM_B = 3'd3;
    localparam logic [2:0] c_IMM_J = 3'd4;

    typedef struct packed {
        logic [31:0] cmd;
        logic        err;
    } enc_entry_t;

endpackage
`default_nettype wire

// File: rtl/imm_scatter.sv
`default_nettype none
// ============================================================================
// Module      : imm_scatter
// Description : Combinational scatter of an immediate into the RISC-V bit
//               positions of its format, merged over a base instruction word.
//               The err output and range check exist only with
//               IMM_RANGE_CHECK_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_scatter
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  op_imm,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic [31:0] cmd
`ifdef IMM_RANGE_CHECK_EN
    ,
    output logic        err
`endif
);

    // Undefined codes fall into the I layout, matching the decoder default.
    always_comb begin
        cmd = base;
        case (op_imm)
            c_IMM_U: cmd[31:12] = imm[31:12];
            c_IMM_J: begin
                cmd[31]    = imm[20];
                cmd[30:21] = imm[10:1];
                cmd[20]    = imm[11];
                cmd[19:12] = imm[19:12];
            end
            c_IMM_S: begin
                cmd[31:25] = imm[11:5];
                cmd[11:7]  = imm[4:0];
            end
            c_IMM_B: begin
                cmd[31]    = imm[12];
                cmd[30:25] = imm[10:5];
                cmd[11:8]  = imm[4:1];
                cmd[7]     = imm[11];
            end
            default: cmd[31:20] = imm[11:0];
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic w_fit_12;
    logic w_fit_13;
    logic w_fit_21;

    // Upper bits must be a pure sign extension of the field's top bit.
    assign w_fit_12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign w_fit_13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign w_fit_21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        err = 1'b0;
        case (op_imm)
            c_IMM_U: err = |imm[11:0];
            c_IMM_J: err = ~w_fit_21 | imm[0];
            c_IMM_B: err = ~w_fit_13 | imm[0];
            default: err = ~w_fit_12;
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder
// Description : Valid/ready immediate encoder with a registered output stage
//               and one skid entry. Define IMM_RANGE_CHECK_EN to report
//               immediates that do not fit their format on err.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op_imm,
    input  logic [31:0]      imm,
    input  logic [31:0]      base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      cmd,
    output logic             err,
    output logic [CNT_W-1:0] enc_cnt
);

    logic [31:0]      w_cmd;
    logic             w_err;
    enc_entry_t       w_entry;
    logic             w_in_fire;
    logic             w_out_free;

    enc_entry_t       r_out;
    logic             r_out_valid;
    enc_entry_t       r_skid;
    logic             r_skid_full;
    logic [CNT_W-1:0] r_enc_cnt;

`ifdef IMM_RANGE_CHECK_EN
    imm_scatter u_scatter (
        .op_imm (op_imm),
        .imm    (imm),
        .base   (base),
        .cmd    (w_cmd),
        .err    (w_err)
    );
`else
    imm_scatter u_scatter (
        .op_imm (op_imm),
        .imm    (imm),
        .base   (base),
        .cmd    (w_cmd)
    );
    assign w_err = 1'b0;
`endif

    assign w_entry    = '{cmd: w_cmd, err: w_err};
    assign in_ready   = ~r_skid_full;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_free = ~r_out_valid | out_ready;

    // The skid only fills while the output is stalled, so an input can never
    // arrive in the same cycle the skid is being emptied.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_skid      <= '0;
            r_skid_full <= 1'b0;
            r_enc_cnt   <= '0;
        end else begin
            if (w_in_fire) begin
                r_enc_cnt <= r_enc_cnt + CNT_W'(1);
            end
            if (w_out_free) begin
                if (r_skid_full) begin
                    r_out       <= r_skid;
                    r_out_valid <= 1'b1;
                    r_skid_full <= 1'b0;
                end else if (w_in_fire) begin
                    r_out       <= w_entry;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_skid      <= w_entry;
                r_skid_full <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign cmd       = r_out.cmd;
    assign err       = r_out.err;
    assign enc_cnt   = r_enc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_encoder
// Description : Scoreboard bench for imm_encoder with encode/decode loopback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op_imm = '0;
    logic [31:0] imm = '0;
    logic [31:0] base = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] cmd;
    logic        err;
    logic [31:0] enc_cnt;

    int errors = 0;
    int checks = 0;
    int n_acc  = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] imm;
        logic [31:0] cmd;
        logic        err;
    } sb_t;
    sb_t sb[$];

    imm_encoder #(.CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_imm    (op_imm),
        .imm       (imm),
        .base      (base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cmd       (cmd),
        .err       (err),
        .enc_cnt   (enc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_enc(input logic [2:0] op, input logic [31:0] v, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            c_IMM_U: r = {v[31:12], b[11:0]};
            c_IMM_J: r = {v[20], v[10:1], v[11], v[19:12], b[11:0]};
            c_IMM_S: r = {v[11:5], b[24:12], v[4:0], b[6:0]};
            c_IMM_B: r = {v[12], v[10:5], b[24:12], v[4:1], v[11], b[6:0]};
            default: r = {v[11:0], b[19:0]};
        endcase
        return r;
    endfunction

    function automatic logic m_err(input logic [2:0] op, input logic [31:0] v);
        logic r;
        r = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        case (op)
            c_IMM_U: r = (v[11:0] != 12'd0);
            c_IMM_J: r = ($signed(v) < -32'sd1048576) || ($signed(v) > 32'sd1048575) || v[0];
            c_IMM_B: r = ($signed(v) < -32'sd4096) || ($signed(v) > 32'sd4095) || v[0];
            default: r = ($signed(v) < -32'sd2048) || ($signed(v) > 32'sd2047);
        endcase
`endif
        return r;
    endfunction

    // Reference decoder: what the NPC decoder recovers from an encoded word.
    function automatic logic [31:0] m_dec(input logic [2:0] op, input logic [31:0] c);
        logic [31:0] r;
        case (op)
            c_IMM_U: r = {c[31:12], 12'd0};
            c_IMM_J: r = {{12{c[31]}}, c[19:12], c[20], c[30:21], 1'b0};
            c_IMM_S: r = {{20{c[31]}}, c[31:25], c[11:7]};
            c_IMM_B: r = {{20{c[31]}}, c[7], c[30:25], c[11:8], 1'b0};
            default: r = {{20{c[31]}}, c[31:20]};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] m_trunc(input logic [2:0] op, input logic [31:0] v);
        logic [31:0] r;
        case (op)
            c_IMM_U: r = v & 32'hFFFF_F000;
            c_IMM_J: r = {{11{v[20]}}, v[20:1], 1'b0};
            c_IMM_B: r = {{19{v[12]}}, v[12:1], 1'b0};
            default: r = {{20{v[11]}}, v[11:0]};
        endcase
        return r;
    endfunction

    // Monitor: pop and compare on output transfers, push on input transfers.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            n_acc = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sb_cmd", cmd, e.cmd);
                    chk("sb_err", {31'd0, err}, {31'd0, e.err});
                    chk("loopback", m_dec(e.op, cmd), m_trunc(e.op, e.imm));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{op: op_imm, imm: imm, cmd: m_enc(op_imm, imm, base),
                               err: m_err(op_imm, imm)});
                n_acc++;
            end
        end
    end

    task automatic set_in(input logic [2:0] op, input logic [31:0] v, input logic [31:0] b);
        op_imm   = op;
        imm      = v;
        base     = b;
        in_valid = 1'b1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] v, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        set_in(op, v, b);
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        chk("accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic drive_chk(input string tag, input logic [2:0] op, input logic [31:0] v,
                             input logic [31:0] b, input logic [31:0] exp_cmd, input logic exp_err);
        drive(op, v, b);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_cmd"}, cmd, exp_cmd);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    bit range_on;

    initial begin
`ifdef IMM_RANGE_CHECK_EN
        range_on = 1'b1;
`else
        range_on = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_cmd", cmd, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cnt", enc_cnt, 32'd0);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        drive_chk("addi", c_IMM_I, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0);
        chk("addi_cnt", enc_cnt, 32'd1);
        drive_chk("jal", c_IMM_J, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0);
        drive_chk("sw", c_IMM_S, 32'hFFFF_FFFC, 32'h0020_A023, 32'hFE20_AE23, 1'b0);
        drive_chk("lui", c_IMM_U, 32'h1234_5000, 32'h0000_00B7, 32'h1234_50B7, 1'b0);
        drive_chk("rng_b", c_IMM_B, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, range_on);
        drive_chk("rng_i", c_IMM_I, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, range_on);
        drive_chk("rng_u", c_IMM_U, 32'h0000_1001, 32'h0000_0037, 32'h0000_1037, range_on);
        drive_chk("undef", 3'd6, 32'h0000_0123, 32'h0000_0013, 32'h1230_0013, 1'b0);

        // Backpressure: two entries fill, the third waits for space.
        pulse_rst();
        out_ready = 1'b0;
        set_in(c_IMM_I, 32'h0000_0001, 32'h0000_0013);
        @(negedge clk); chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        set_in(c_IMM_I, 32'h0000_0002, 32'h0000_0013);
        @(negedge clk); chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        set_in(c_IMM_I, 32'h0000_0003, 32'h0000_0013);
        @(negedge clk); chk("bp_full", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk); chk("bp_out0", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_out1", {31'd0, out_valid}, 32'd1);
        chk("bp_rdy2", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out2", {31'd0, out_valid}, 32'd1);
        chk("bp_cnt", enc_cnt, 32'd3);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_idle", {31'd0, out_valid}, 32'd0);

        // Reset with both entries occupied.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(c_IMM_S, 32'h0000_0010, 32'h0000_0023);
        drive(c_IMM_S, 32'h0000_0020, 32'h0000_0023);
        @(negedge clk); chk("mr_full", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_ready", {31'd0, in_ready}, 32'd1);
        chk("mr_cnt", enc_cnt, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive_chk("mr_next", c_IMM_U, 32'hABCD_E000, 32'h0000_0537, 32'hABCD_E537, 1'b0);

        // Random formats, immediates and backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [31:0] v;
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 8191) - 32'd4096;
                1: v = $urandom_range(0, 32'h1F_FFFF) - 32'h10_0000;
                2: v = {$urandom_range(0, 32'hF_FFFF), 12'd0};
                default: v = $urandom;
            endcase
            drive(3'($urandom_range(0, 7)), v, $urandom);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain", sb.size(), 32'd0);
        chk("final_cnt", enc_cnt, n_acc);
        chk("final_idle", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
